// File: rtl/dc_mcl_line_fetch_scheduler_pkg.sv
// Shared types and constants for the main-control-logic fetch side.
package dc_mcl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

    localparam int NUM_OF_LINES_FOR_IPU = 4;

    // Index width for a ring of n slots; a single slot still needs one bit.
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dc_mcl_line_fetch_scheduler_if.sv
// Request, frame-memory read and line-buffer write bundle of the fetch scheduler.
interface dc_mcl_line_fetch_scheduler_if #(
    parameter int LINE_NUMBER_WIDTH = 11,
    parameter int ADDR_WIDTH        = 32,
    parameter int WORDS_WIDTH       = 12,
    parameter int BURST_LEN         = 16,
    parameter int NUM_SLOTS         = 5
);
    import dc_mcl_pkg::*;

    localparam int LEN_W  = $clog2(BURST_LEN);
    localparam int SLOT_W = slot_w(NUM_SLOTS);

    logic [LINE_NUMBER_WIDTH-1:0] line_number;
    logic                         line_data_valid;
    logic                         line_data_ready;
    logic                         rd_cmd_valid;
    logic                         rd_cmd_ready;
    logic [ADDR_WIDTH-1:0]        rd_cmd_addr;
    logic [LEN_W-1:0]             rd_cmd_len;
    logic                         rd_data_valid;
    logic                         rd_data_last;
    logic                         wr_en;
    logic [SLOT_W-1:0]            wr_slot;
    logic [WORDS_WIDTH-1:0]       wr_word_addr;
    logic                         line_done;
    logic [SLOT_W-1:0]            done_slot;

    modport master (
        input  line_number, line_data_valid, rd_cmd_ready, rd_data_valid, rd_data_last,
        output line_data_ready, rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
               wr_en, wr_slot, wr_word_addr, line_done, done_slot
    );

    modport slave (
        output line_number, line_data_valid, rd_cmd_ready, rd_data_valid, rd_data_last,
        input  line_data_ready, rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
               wr_en, wr_slot, wr_word_addr, line_done, done_slot
    );

endinterface

// File: rtl/dc_mcl_burst_issuer.sv
// Splits a line into burst read commands and tracks issued-but-incomplete bursts.
module dc_mcl_burst_issuer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int WORDS_WIDTH     = 12,
    parameter int BURST_LEN       = 16,
    parameter int BYTES_PER_WORD  = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         en,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         active,
    input  logic [ADDR_WIDTH-1:0]        addr_in,
    input  logic [WORDS_WIDTH-1:0]       words_in,
    input  logic                         rd_cmd_ready,
    input  logic                         rd_data_valid,
    input  logic                         rd_data_last,
    output logic                         rd_cmd_valid,
    output logic [ADDR_WIDTH-1:0]        rd_cmd_addr,
    output logic [$clog2(BURST_LEN)-1:0] rd_cmd_len,
    output logic                         all_issued,
    output logic                         no_outstanding
);
    localparam int LEN_W = $clog2(BURST_LEN);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [ADDR_WIDTH-1:0]  addr;
    logic [WORDS_WIDTH-1:0] remaining;
    logic [WORDS_WIDTH-1:0] beats;
    logic [CNT_W-1:0]       outstanding;
    logic                   hs;
    logic                   ret;

    assign beats          = (remaining > WORDS_WIDTH'(BURST_LEN)) ? WORDS_WIDTH'(BURST_LEN) : remaining;
    assign all_issued     = (remaining == '0);
    assign no_outstanding = (outstanding == '0);
    assign rd_cmd_valid   = active && !all_issued && (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign rd_cmd_addr    = addr;
    assign rd_cmd_len     = all_issued ? '0 : LEN_W'(beats - WORDS_WIDTH'(1));

    // Memory shares en, so frozen cycles never count as handshakes.
    assign hs  = en && rd_cmd_valid && rd_cmd_ready;
    assign ret = en && rd_data_valid && rd_data_last && !no_outstanding;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr      <= '0;
            remaining <= '0;
        end else if (en) begin
            if (start) begin
                addr      <= addr_in;
                remaining <= words_in;
            end else if (abort) begin
                remaining <= '0;
            end else if (hs) begin
                addr      <= addr + ADDR_WIDTH'(BURST_LEN * BYTES_PER_WORD);
                remaining <= remaining - beats;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            outstanding <= '0;
        else if (hs && !ret)
            outstanding <= outstanding + CNT_W'(1);
        else if (!hs && ret)
            outstanding <= outstanding - CNT_W'(1);
    end

endmodule

// File: rtl/dc_mcl_line_fetch_scheduler.sv
// Fetch-unit line scheduler: one line at a time, burst reads, beats steered into a slot ring.
module dc_mcl_line_fetch_scheduler
    import dc_mcl_pkg::*;
#(
    parameter int LINE_NUMBER_WIDTH = 11,
    parameter int ADDR_WIDTH        = 32,
    parameter int WORDS_WIDTH       = 12,
    parameter int BURST_LEN         = 16,
    parameter int BYTES_PER_WORD    = 4,
    parameter int MAX_OUTSTANDING   = 4,
    parameter int NUM_SLOTS         = 5
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   en,
    input  logic                   frame_start,
    input  logic                   abort,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH-1:0]  line_stride,
    input  logic [WORDS_WIDTH-1:0] line_words,
    dc_mcl_line_fetch_scheduler_if.master bus
);
    localparam int SLOT_W = slot_w(NUM_SLOTS);

    fsm_state_t                   state, state_nxt;
    logic                         flush;
    logic [SLOT_W-1:0]            slot_ptr;
    logic [SLOT_W-1:0]            done_slot_q;
    logic [WORDS_WIDTH-1:0]       beat_cnt;
    logic [LINE_NUMBER_WIDTH-1:0] line_number;
    logic [ADDR_WIDTH-1:0]        line_addr;
    logic                         accept, in_line, abort_act, wr_en;
    logic                         all_issued, no_outstanding;

    assign line_number = bus.line_number;
    assign line_addr   = base_addr + ADDR_WIDTH'(line_number) * line_stride;
    assign accept      = en && bus.line_data_valid && (state == ST_IDLE);
    assign in_line     = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign abort_act   = en && abort && in_line;
    // Beats of an aborted line are still consumed so the outstanding count drains.
    assign wr_en       = en && bus.rd_data_valid && in_line && !flush;

    dc_mcl_burst_issuer #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .WORDS_WIDTH    (WORDS_WIDTH),
        .BURST_LEN      (BURST_LEN),
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_issuer (
        .clk           (clk),
        .nrst          (nrst),
        .en            (en),
        .start         (accept),
        .abort         (abort_act),
        .active        (state == ST_ISSUE),
        .addr_in       (line_addr),
        .words_in      (line_words),
        .rd_cmd_ready  (bus.rd_cmd_ready),
        .rd_data_valid (bus.rd_data_valid),
        .rd_data_last  (bus.rd_data_last),
        .rd_cmd_valid  (bus.rd_cmd_valid),
        .rd_cmd_addr   (bus.rd_cmd_addr),
        .rd_cmd_len    (bus.rd_cmd_len),
        .all_issued    (all_issued),
        .no_outstanding(no_outstanding)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (abort_act)       state_nxt = ST_DRAIN;
                else if (all_issued) state_nxt = no_outstanding ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: if (no_outstanding) state_nxt = (flush || abort_act) ? ST_IDLE : ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= ST_IDLE;
            flush       <= 1'b0;
            slot_ptr    <= '0;
            done_slot_q <= '0;
            beat_cnt    <= '0;
        end else if (en) begin
            state <= state_nxt;
            if (accept) begin
                beat_cnt <= '0;
                flush    <= 1'b0;
            end else if (wr_en) begin
                beat_cnt <= beat_cnt + WORDS_WIDTH'(1);
            end
            if (abort_act)
                flush <= 1'b1;
            if (state == ST_IDLE && frame_start)
                slot_ptr <= '0;
            else if (state == ST_DONE)
                slot_ptr <= (slot_ptr == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_ptr + SLOT_W'(1);
            if (state_nxt == ST_DONE && state != ST_DONE)
                done_slot_q <= slot_ptr;
        end
    end

    assign bus.line_data_ready = (state == ST_IDLE);
    assign bus.line_done       = (state == ST_DONE);
    assign bus.done_slot       = done_slot_q;
    assign bus.wr_en           = wr_en;
    assign bus.wr_slot         = slot_ptr;
    assign bus.wr_word_addr    = beat_cnt;

endmodule

// File: tb/tb_dc_mcl_line_fetch_scheduler.sv
// Scoreboard bench: directed lines push expected commands/writes/completions; a monitor pops them.
module tb_dc_mcl_line_fetch_scheduler;

    typedef struct packed { logic [31:0] addr; logic [3:0] len; } cmd_t;
    typedef struct packed { logic [2:0] slot; logic [11:0] word; } wr_t;

    logic        clk = 1'b0, nrst = 1'b0, en = 1'b0, frame_start = 1'b0, abort = 1'b0;
    logic [31:0] base_addr = '0, line_stride = '0;
    logic [11:0] line_words = '0;

    int n_chk = 0, n_err = 0, n_cmd = 0;
    cmd_t        exp_cmd[$];
    wr_t         exp_wr[$];
    logic [2:0]  exp_done[$];
    cmd_t        mc;
    wr_t         mw;
    logic [2:0]  md;

    dc_mcl_line_fetch_scheduler_if bus ();

    dc_mcl_line_fetch_scheduler dut (
        .clk(clk), .nrst(nrst), .en(en), .frame_start(frame_start), .abort(abort),
        .base_addr(base_addr), .line_stride(line_stride), .line_words(line_words), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        n_chk++;
        n_err++;
        $display("FAIL %s: got 0x%0h with nothing expected (t=%0t)", name, act, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_c(input logic [31:0] a, input logic [3:0] l);
        cmd_t c;
        c.addr = a;
        c.len  = l;
        exp_cmd.push_back(c);
    endtask

    task automatic exp_line(input logic [2:0] slot, input int words, input bit done);
        wr_t w;
        for (int i = 0; i < words; i++) begin
            w.slot = slot;
            w.word = 12'(i);
            exp_wr.push_back(w);
        end
        if (done) exp_done.push_back(slot);
    endtask

    task automatic req(input logic [10:0] ln, input logic [11:0] w, input logic [31:0] b, input logic [31:0] s);
        int t = 0;
        while (!bus.line_data_ready && t < 300) begin tick(); t++; end
        if (!bus.line_data_ready) flag("req_ready_timeout", 64'(t));
        base_addr = b; line_stride = s; line_words = w; bus.line_number = ln;
        bus.line_data_valid = 1'b1;
        tick();
        bus.line_data_valid = 1'b0;
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rd_data_valid = 1'b1;
            bus.rd_data_last  = (i == n - 1);
            tick();
        end
        bus.rd_data_valid = 1'b0;
        bus.rd_data_last  = 1'b0;
    endtask

    task automatic wait_cmds(input int target, input string name);
        int t = 0;
        while (n_cmd < target && t < 100) begin tick(); t++; end
        if (n_cmd < target) flag(name, 64'(n_cmd));
    endtask

    task automatic wait_line(input string name);
        int t = 0;
        while (!(bus.line_data_ready && exp_done.size() == 0) && t < 300) begin tick(); t++; end
        if (!(bus.line_data_ready && exp_done.size() == 0)) flag(name, 64'(exp_done.size()));
    endtask

    // Monitor: every DUT-presented event is matched against the head of its queue.
    initial begin
        forever begin
            @(negedge clk);
            if (nrst) begin
                if (en && bus.rd_cmd_valid && bus.rd_cmd_ready) begin
                    n_cmd++;
                    if (exp_cmd.size() == 0) flag("cmd_unexpected", 64'(bus.rd_cmd_addr));
                    else begin
                        mc = exp_cmd.pop_front();
                        check("cmd_addr", 64'(bus.rd_cmd_addr), 64'(mc.addr));
                        check("cmd_len", 64'(bus.rd_cmd_len), 64'(mc.len));
                    end
                end
                if (bus.wr_en) begin
                    if (exp_wr.size() == 0) flag("wr_unexpected", 64'(bus.wr_word_addr));
                    else begin
                        mw = exp_wr.pop_front();
                        check("wr_slot", 64'(bus.wr_slot), 64'(mw.slot));
                        check("wr_word_addr", 64'(bus.wr_word_addr), 64'(mw.word));
                    end
                end
                if (bus.line_done) begin
                    if (exp_done.size() == 0) flag("done_unexpected", 64'(bus.done_slot));
                    else begin
                        md = exp_done.pop_front();
                        check("done_slot", 64'(bus.done_slot), 64'(md));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        int n0, t;
        logic [2:0] s;
        bus.line_number = '0; bus.line_data_valid = 1'b0; bus.rd_cmd_ready = 1'b0;
        bus.rd_data_valid = 1'b1; bus.rd_data_last = 1'b1;
        en = 1'b1;
        tick(); tick();
        // Reset state (beats presented during reset must not be written).
        check("rst_ready", 64'(bus.line_data_ready), 64'd1);
        check("rst_cmd_valid", 64'(bus.rd_cmd_valid), 64'd0);
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("rst_line_done", 64'(bus.line_done), 64'd0);
        check("rst_done_slot", 64'(bus.done_slot), 64'd0);
        check("rst_cmd_addr", 64'(bus.rd_cmd_addr), 64'd0);
        check("rst_cmd_len", 64'(bus.rd_cmd_len), 64'd0);
        check("rst_wr_word_addr", 64'(bus.wr_word_addr), 64'd0);
        bus.rd_data_valid = 1'b0; bus.rd_data_last = 1'b0;
        nrst = 1'b1;
        tick();

        // Line 3 of base 0x1000 stride 0x200 -> 0x1600, 40 words in three bursts.
        exp_c(32'h1600, 4'd15); exp_c(32'h1640, 4'd15); exp_c(32'h1680, 4'd7);
        exp_line(3'd0, 40, 1'b1);
        n0 = n_cmd;
        bus.rd_cmd_ready = 1'b1;
        req(11'd3, 12'd40, 32'h1000, 32'h200);
        check("t1_ready_low", 64'(bus.line_data_ready), 64'd0);
        wait_cmds(n0 + 3, "t1_cmds_timeout");
        burst(16); burst(16); burst(8);
        t = 0;
        while (!bus.line_done && t < 50) begin tick(); t++; end
        if (!bus.line_done) flag("t1_done_timeout", 64'(t));
        else begin
            check("t1_ready_in_done", 64'(bus.line_data_ready), 64'd0);
            tick();
            check("t1_ready_after_done", 64'(bus.line_data_ready), 64'd1);
            check("t1_done_one_cycle", 64'(bus.line_done), 64'd0);
        end
        check("t1_cmd_count", 64'(n_cmd - n0), 64'd3);

        // Stall the second command five cycles: it must hold still and not repeat.
        exp_c(32'h0500, 4'd15); exp_c(32'h0540, 4'd3);
        exp_line(3'd1, 20, 1'b1);
        n0 = n_cmd;
        req(11'd5, 12'd20, 32'h0, 32'h100);
        tick();
        bus.rd_cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 64'(bus.rd_cmd_valid), 64'd1);
            check("t2_hold_addr", 64'(bus.rd_cmd_addr), 64'h540);
            check("t2_hold_len", 64'(bus.rd_cmd_len), 64'd3);
            tick();
        end
        check("t2_no_extra_cmd", 64'(n_cmd - n0), 64'd1);
        bus.rd_cmd_ready = 1'b1;
        wait_cmds(n0 + 2, "t2_cmds_timeout");
        burst(16); burst(4);
        wait_line("t2_done_timeout");

        // 128 words with no returns: capped at four commands until a burst completes.
        for (int k = 0; k < 8; k++) exp_c(32'h2000_2000 + 32'(k * 64), 4'd15);
        exp_line(3'd2, 128, 1'b1);
        n0 = n_cmd;
        req(11'd2, 12'd128, 32'h2000_0000, 32'h1000);
        repeat (10) tick();
        check("t3_cap_count", 64'(n_cmd - n0), 64'd4);
        check("t3_cap_valid", 64'(bus.rd_cmd_valid), 64'd0);
        burst(16);
        repeat (4) tick();
        check("t3_fifth_cmd", 64'(n_cmd - n0), 64'd5);
        repeat (7) burst(16);
        wait_line("t3_done_timeout");
        check("t3_cmd_count", 64'(n_cmd - n0), 64'd8);

        // Second command handshakes on the same edge as the first burst's last beat.
        exp_c(32'h4040, 4'd15); exp_c(32'h4080, 4'd15);
        exp_line(3'd3, 32, 1'b1);
        n0 = n_cmd;
        req(11'd1, 12'd32, 32'h4000, 32'h40);
        tick();
        bus.rd_cmd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.rd_data_valid = 1'b1;
            bus.rd_data_last  = (i == 15);
            if (i == 15) bus.rd_cmd_ready = 1'b1;
            tick();
        end
        bus.rd_data_valid = 1'b0; bus.rd_data_last = 1'b0;
        check("t4_same_cycle_cmds", 64'(n_cmd - n0), 64'd2);
        check("t4_still_busy", 64'(bus.line_data_ready), 64'd0);
        burst(16);
        wait_line("t4_done_timeout");

        // Slot ring: frame_start, six lines wrap 0..4,0, frame_start again, next line slot 0.
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) begin frame_start = 1'b1; tick(); frame_start = 1'b0; end
            s = (k == 6) ? 3'd0 : 3'(k % 5);
            exp_c(32'(k * 16), 4'd3);
            exp_line(s, 4, 1'b1);
            n0 = n_cmd;
            req(11'(k), 12'd4, 32'h0, 32'h10);
            wait_cmds(n0 + 1, "t5_cmd_timeout");
            burst(4);
            wait_line("t5_done_timeout");
        end

        // Abort after two commands: no further commands, returned beats dropped, no completion.
        exp_c(32'h8000, 4'd15); exp_c(32'h8040, 4'd15);
        n0 = n_cmd;
        req(11'd0, 12'd128, 32'h8000, 32'h0);
        tick(); tick();
        bus.rd_cmd_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_valid_dropped", 64'(bus.rd_cmd_valid), 64'd0);
        bus.rd_cmd_ready = 1'b1;
        repeat (3) tick();
        check("t6_cmd_count", 64'(n_cmd - n0), 64'd2);
        burst(16); burst(16);
        wait_line("t6_idle_timeout");

        // Zero-word line: completes two cycles after accept with the unadvanced slot.
        exp_done.push_back(3'd1);
        n0 = n_cmd;
        req(11'd7, 12'd0, 32'h9000, 32'h100);
        check("t7_cycle1_no_done", 64'(bus.line_done), 64'd0);
        tick();
        check("t7_cycle2_done", 64'(bus.line_done), 64'd1);
        check("t7_done_slot", 64'(bus.done_slot), 64'd1);
        tick();
        check("t7_ready_back", 64'(bus.line_data_ready), 64'd1);
        check("t7_no_cmds", 64'(n_cmd - n0), 64'd0);

        repeat (3) tick();
        check("left_cmds", 64'(exp_cmd.size()), 64'd0);
        check("left_writes", 64'(exp_wr.size()), 64'd0);
        check("left_dones", 64'(exp_done.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
